// File: rtl/traffic_sensor_cond_pkg.sv
// traffic_sensor_cond_pkg: shared state encoding and counter sizing for the detector conditioner
package traffic_sensor_cond_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, OCC = 2'd1, HOLD = 2'd2, FAULT = 2'd3} state_t;
   function automatic int cnt_width(input int deb, input int hold, input int stuck);
      int m;
      m = (deb > hold) ? deb : hold;
      m = (stuck > m) ? stuck : m;
      return $clog2(m + 1);
   endfunction
endpackage

// File: rtl/sensor_channel.sv
// sensor_channel: one detector channel -- synchroniser, debounce/gap-hold/stuck FSM, sticky fault flag
//   clk       in  rising-edge clock
//   rst       in  asynchronous active-high reset
//   raw       in  raw asynchronous detector input
//   clr_fault in  one-cycle pulse clearing the sticky fault flag
//   t         out conditioned occupancy (state != IDLE)
//   fault     out sticky stuck-detector flag
module sensor_channel
   import traffic_sensor_cond_pkg::*;
#(
   parameter int DEB_CYCLES   = 3,
   parameter int HOLD_CYCLES  = 4,
   parameter int STUCK_CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   input  logic clr_fault,
   output logic t,
   output logic fault
);
   localparam int CW = cnt_width(DEB_CYCLES, HOLD_CYCLES, STUCK_CYCLES);
   localparam logic [CW-1:0] DEB_LAST   = CW'(DEB_CYCLES - 1);
   localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] STUCK_LAST = CW'(STUCK_CYCLES - 1);
   logic [1:0]    sync_q, sync_d;
   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          fault_q, fault_d;
   logic          s;
   assign s = sync_q[1];
   always_comb begin
      sync_d  = {sync_q[0], raw};
      state_d = state_q;
      cnt_d   = cnt_q;
      // clear is applied first so a same-edge fault entry below overrides it
      fault_d = clr_fault ? 1'b0 : fault_q;
      case (state_q)
         IDLE: begin
            cnt_d   = !s ? '0 : (cnt_q == DEB_LAST) ? '0 : cnt_q + CW'(1);
            state_d = (s && cnt_q == DEB_LAST) ? OCC : IDLE;
         end
         OCC: begin
            if (!s) begin
               state_d = HOLD;
               cnt_d   = '0;
            end else if (cnt_q == STUCK_LAST) begin
               state_d = FAULT;
               cnt_d   = '0;
               fault_d = 1'b1;
            end else begin
               cnt_d   = cnt_q + CW'(1);
            end
         end
         HOLD: begin
            // a returning vehicle resumes occupancy without re-debounce
            cnt_d   = (s || cnt_q == HOLD_LAST) ? '0 : cnt_q + CW'(1);
            state_d = s ? OCC : (cnt_q == HOLD_LAST) ? IDLE : HOLD;
         end
         FAULT: begin
            cnt_d   = (s || cnt_q == DEB_LAST) ? '0 : cnt_q + CW'(1);
            state_d = (!s && cnt_q == DEB_LAST) ? IDLE : FAULT;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q  <= '0;
         state_q <= IDLE;
         cnt_q   <= '0;
         fault_q <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         fault_q <= fault_d;
      end
   end
   assign t     = (state_q != IDLE);
   assign fault = fault_q;
endmodule

// File: rtl/traffic_sensor_cond.sv
// traffic_sensor_cond: conditions two raw vehicle detectors into T_A/T_B occupancy flags
//   CLK       in  rising-edge clock
//   reset     in  asynchronous active-high reset
//   raw_A/B   in  raw asynchronous detector inputs
//   clr_fault in  one-cycle pulse clearing both sticky fault flags
//   T_A/B     out conditioned occupancy (forced high while a detector is stuck)
//   fault_A/B out sticky stuck-detector flags
module traffic_sensor_cond
   import traffic_sensor_cond_pkg::*;
#(
   parameter int DEB_CYCLES   = 3,
   parameter int HOLD_CYCLES  = 4,
   parameter int STUCK_CYCLES = 16
) (
   input  logic CLK,
   input  logic reset,
   input  logic raw_A,
   input  logic raw_B,
   input  logic clr_fault,
   output logic T_A,
   output logic T_B,
   output logic fault_A,
   output logic fault_B
);
   sensor_channel #(
      .DEB_CYCLES(DEB_CYCLES), .HOLD_CYCLES(HOLD_CYCLES), .STUCK_CYCLES(STUCK_CYCLES)
   ) u_ch_a (
      .clk(CLK), .rst(reset), .raw(raw_A), .clr_fault(clr_fault), .t(T_A), .fault(fault_A)
   );
   sensor_channel #(
      .DEB_CYCLES(DEB_CYCLES), .HOLD_CYCLES(HOLD_CYCLES), .STUCK_CYCLES(STUCK_CYCLES)
   ) u_ch_b (
      .clk(CLK), .rst(reset), .raw(raw_B), .clr_fault(clr_fault), .t(T_B), .fault(fault_B)
   );
endmodule

// File: tb/tb_traffic_sensor_cond.sv
// tb_traffic_sensor_cond: directed self-checking bench for traffic_sensor_cond
module tb_traffic_sensor_cond;
   logic CLK = 1'b0, reset = 1'b1, raw_A = 1'b0, raw_B = 1'b0, clr_fault = 1'b0;
   logic T_A, T_B, fault_A, fault_B;
   int   n_checks = 0, n_fail = 0;
   traffic_sensor_cond dut (
      .CLK(CLK), .reset(reset), .raw_A(raw_A), .raw_B(raw_B), .clr_fault(clr_fault),
      .T_A(T_A), .T_B(T_B), .fault_A(fault_A), .fault_B(fault_B)
   );
   always #5 CLK = ~CLK;
   // advance n rising edges, then settle 1 time unit past the last one
   task automatic tick(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask
   task automatic chk(input string tag, input logic obs, input logic exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask
   initial begin
      tick(2);
      chk("rst_T_A", T_A, 1'b0);
      chk("rst_T_B", T_B, 1'b0);
      chk("rst_fault_A", fault_A, 1'b0);
      chk("rst_fault_B", fault_B, 1'b0);
      // 1: debounce latency, then asynchronous reset mid-OCC
      reset = 1'b0;
      raw_A = 1'b1;
      tick(4);
      chk("deb_not_yet", T_A, 1'b0);
      tick(1);
      chk("deb_rise", T_A, 1'b1);
      #2 reset = 1'b1;
      #1 chk("async_rst", T_A, 1'b0);
      tick(1);
      reset = 1'b0;
      tick(4);
      chk("post_rst_not_yet", T_A, 1'b0);
      tick(1);
      chk("post_rst_rise", T_A, 1'b1);
      // gap hold: high through m+5, low after m+6
      raw_A = 1'b0;
      tick(6);
      chk("hold_m5", T_A, 1'b1);
      tick(1);
      chk("hold_fall_m6", T_A, 1'b0);
      // 2: 2-cycle glitch ignored, 3-cycle pulse accepted
      raw_A = 1'b1;
      tick(2);
      raw_A = 1'b0;
      tick(6);
      chk("glitch2", T_A, 1'b0);
      raw_A = 1'b1;
      tick(3);
      raw_A = 1'b0;
      tick(1);
      chk("pulse3_k3", T_A, 1'b0);
      tick(1);
      chk("pulse3_k4", T_A, 1'b1);
      tick(4);
      chk("pulse3_m5", T_A, 1'b1);
      tick(1);
      chk("pulse3_m6", T_A, 1'b0);
      // 3: re-rise during HOLD keeps T asserted
      raw_A = 1'b1;
      tick(5);
      chk("rerise_up", T_A, 1'b1);
      raw_A = 1'b0;
      tick(3);
      raw_A = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick(1);
         chk("rerise_hold", T_A, 1'b1);
      end
      raw_A = 1'b0;
      tick(12);
      chk("rerise_idle", T_A, 1'b0);
      // 4: stuck detector, fault exit, clear
      raw_A = 1'b1;
      tick(20);
      chk("stuck_pre_fault", fault_A, 1'b0);
      tick(1);
      chk("stuck_fault", fault_A, 1'b1);
      chk("stuck_T", T_A, 1'b1);
      raw_A = 1'b0;
      tick(4);
      chk("fault_exit_m3", T_A, 1'b1);
      tick(1);
      chk("fault_exit_m4", T_A, 1'b0);
      chk("fault_sticky", fault_A, 1'b1);
      clr_fault = 1'b1;
      tick(1);
      clr_fault = 1'b0;
      chk("fault_cleared", fault_A, 1'b0);
      // 5: set beats clear on the entry edge; paired channels track
      raw_A = 1'b1;
      tick(20);
      clr_fault = 1'b1;
      tick(1);
      clr_fault = 1'b0;
      chk("set_wins", fault_A, 1'b1);
      raw_A = 1'b0;
      tick(6);
      clr_fault = 1'b1;
      tick(1);
      clr_fault = 1'b0;
      chk("reclear", fault_A, 1'b0);
      chk("reclear_T", T_A, 1'b0);
      raw_A = 1'b1;
      raw_B = 1'b1;
      tick(5);
      chk("pair_up_A", T_A, 1'b1);
      chk("pair_up_B", T_B, 1'b1);
      raw_A = 1'b0;
      raw_B = 1'b0;
      tick(7);
      chk("pair_dn_A", T_A, 1'b0);
      chk("pair_dn_B", T_B, 1'b0);
      // 6: B stuck while A only glitches
      raw_B = 1'b1;
      for (int i = 0; i < 5; i++) begin
         raw_A = 1'b1;
         tick(2);
         raw_A = 1'b0;
         tick(2);
         chk("indep_T_A", T_A, 1'b0);
      end
      chk("indep_pre_fault_B", fault_B, 1'b0);
      tick(1);
      chk("indep_fault_B", fault_B, 1'b1);
      chk("indep_T_B", T_B, 1'b1);
      chk("indep_fault_A", fault_A, 1'b0);
      chk("indep_T_A_end", T_A, 1'b0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
